fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_ctrl_pkg.sv | 19 +
 rtl/fifo_ctrl_if.sv | 46 ++++
 rtl/fifo_ctrl.sv | 114 +++++++++++
 tb/tb_fifo_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_pkg
// Shared constants for the FIFO pointer/flag controller: default address
// width, the matching storage depth, the almost-full / almost-empty threshold
// defaults, and a helper that turns an address width into a depth.
// -----------------------------------------------------------------------------
package fifo_ctrl_pkg;

    localparam int DEF_ADDR_BITS = 3;
    localparam int DEF_DEPTH     = 1 << DEF_ADDR_BITS;
    localparam int DEF_AFULL_TH  = 6;
    localparam int DEF_AEMPTY_TH = 1;

    // Number of storage entries addressed by an addr_bits-wide address.
    function automatic int depth_of(input int addr_bits);
        return 1 << addr_bits;
    endfunction

endpackage : fifo_ctrl_pkg

// File: rtl/fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_if
// Bundles the request, storage-control and status signals of the FIFO
// controller.
//   master : producer/consumer side -- drives wr, rd, clr_err; observes the rest
//   slave  : fifo_ctrl side         -- receives wr, rd, clr_err; drives the rest
// Signals:
//   wr, rd, clr_err           push request, pop request, sticky-error clear
//   wr_en, w_addr, r_addr     storage write enable / write address / read address
//   full, empty               occupancy == depth / occupancy == 0
//   almost_full, almost_empty count >= AFULL_TH / count <= AEMPTY_TH
//   count                     occupancy, 0..depth
//   overflow, underflow       sticky error flags
// ADDR_BITS must match the ADDR_BITS of the fifo_ctrl it is bound to.
// -----------------------------------------------------------------------------
interface fifo_ctrl_if
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS
);
    logic                 wr;
    logic                 rd;
    logic                 clr_err;
    logic                 wr_en;
    logic [ADDR_BITS-1:0] w_addr;
    logic [ADDR_BITS-1:0] r_addr;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [ADDR_BITS:0]   count;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output wr, rd, clr_err,
        input  wr_en, w_addr, r_addr, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr, rd, clr_err,
        output wr_en, w_addr, r_addr, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface : fifo_ctrl_if

// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
// Pointer and flag logic for a first-word-fall-through FIFO. The storage array
// is a separate instance: the producer drives its write-data port directly,
// this block supplies wr_en/w_addr, and the storage's combinational read port
// is addressed by r_addr (always the head entry).
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous, active-high; clears pointers and error flags
//   bus    fifo_ctrl_if.slave -- requests in, storage control and status out
// Parameters:
//   ADDR_BITS  address width; depth = 2**ADDR_BITS
//   AFULL_TH   almost_full when count >= AFULL_TH
//   AEMPTY_TH  almost_empty when count <= AEMPTY_TH
// -----------------------------------------------------------------------------
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int AFULL_TH  = DEF_AFULL_TH,
    parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
    input  logic        clk,
    input  logic        reset,
    fifo_ctrl_if.slave  bus
);

    localparam int DEPTH = depth_of(ADDR_BITS);

    // Thresholds fit in ADDR_BITS+1 bits once the range check below passes.
    localparam logic [ADDR_BITS:0] AFULL_CNT  = (ADDR_BITS+1)'(AFULL_TH);
    localparam logic [ADDR_BITS:0] AEMPTY_CNT = (ADDR_BITS+1)'(AEMPTY_TH);

    generate
        if (AFULL_TH > DEPTH || AEMPTY_TH >= DEPTH || AFULL_TH < 0 || AEMPTY_TH < 0) begin : g_bad_cfg
            $error("fifo_ctrl: thresholds out of range for ADDR_BITS=%0d", ADDR_BITS);
        end
    endgenerate

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_BITS:0] head_q, head_d;
    logic [ADDR_BITS:0] tail_q, tail_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic               full_w;
    logic               empty_w;
    logic [ADDR_BITS:0] count_w;
    logic               push_ok;
    logic               pop_ok;
    logic               ovf_evt;
    logic               udf_evt;

    // Natural ADDR_BITS+1 rollover gives the modulo wrap of both pointers.
    function automatic logic [ADDR_BITS:0] ptr_inc(input logic [ADDR_BITS:0] p);
        return p + 1'b1;
    endfunction

    // Status is decoded from registered pointers only.
    assign empty_w = (head_q == tail_q);
    assign full_w  = (head_q[ADDR_BITS] != tail_q[ADDR_BITS]) &&
                     (head_q[ADDR_BITS-1:0] == tail_q[ADDR_BITS-1:0]);
    assign count_w = tail_q - head_q;

    // A simultaneous pop frees the slot, so a push while full is still taken.
    assign push_ok = bus.wr & (~full_w | bus.rd);
    assign pop_ok  = bus.rd & ~empty_w;
    assign ovf_evt = bus.wr & ~bus.rd & full_w;
    assign udf_evt = bus.rd & empty_w;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push_ok) tail_d = ptr_inc(tail_q);
        if (pop_ok)  head_d = ptr_inc(head_q);

        // A new error wins over a clear in the same cycle.
        if (ovf_evt)          overflow_d = 1'b1;
        else if (bus.clr_err) overflow_d = 1'b0;

        if (udf_evt)          underflow_d = 1'b1;
        else if (bus.clr_err) underflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage must not be written while the pointers are being reset.
    assign bus.wr_en        = push_ok & ~reset;
    assign bus.w_addr       = tail_q[ADDR_BITS-1:0];
    assign bus.r_addr       = head_q[ADDR_BITS-1:0];
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.count        = count_w;
    assign bus.almost_full  = (count_w >= AFULL_CNT);
    assign bus.almost_empty = (count_w <= AEMPTY_CNT);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule : fifo_ctrl

// File: tb/tb_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_ctrl
// Directed stimulus for fifo_ctrl (ADDR_BITS=3, AFULL_TH=6, AEMPTY_TH=1).
// Each stimulus step predicts what the DUT must show during that cycle from a
// behavioural occupancy/head/tail model and queues it; a monitor on the
// falling edge pops each prediction and compares it to the DUT outputs.
// -----------------------------------------------------------------------------
module tb_fifo_ctrl;

    typedef struct packed {
        logic       wr_en;
        logic [2:0] w_addr;
        logic [2:0] r_addr;
        logic       full;
        logic       empty;
        logic       afull;
        logic       aempty;
        logic [3:0] count;
        logic       ovf;
        logic       udf;
    } obs_t;

    logic clk = 1'b0;
    logic reset;

    fifo_ctrl_if #(.ADDR_BITS(3)) bus ();

    fifo_ctrl #(
        .ADDR_BITS (3),
        .AFULL_TH  (6),
        .AEMPTY_TH (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    obs_t  exp_q[$];
    string name_q[$];
    int    tests = 0;
    int    fails = 0;

    // Behavioural model: occupancy and plain modulo-8 addresses.
    int m_cnt, m_head, m_tail;
    bit m_ovf, m_udf;

    function automatic string fmt(input obs_t o);
        return $sformatf("we=%0b wa=%0d ra=%0d full=%0b empty=%0b af=%0b ae=%0b cnt=%0d ovf=%0b udf=%0b",
                         o.wr_en, o.w_addr, o.r_addr, o.full, o.empty, o.afull, o.aempty,
                         o.count, o.ovf, o.udf);
    endfunction

    task automatic step(input bit w, input bit r, input bit c, input bit rs, input string nm);
        obs_t e;
        bit   push, pop;
        @(posedge clk);
        #1;
        bus.wr      = w;
        bus.rd      = r;
        bus.clr_err = c;
        reset       = rs;

        e.wr_en  = !rs && w && (m_cnt < 8 || r);
        e.w_addr = 3'(m_tail);
        e.r_addr = 3'(m_head);
        e.full   = (m_cnt == 8);
        e.empty  = (m_cnt == 0);
        e.afull  = (m_cnt >= 6);
        e.aempty = (m_cnt <= 1);
        e.count  = 4'(m_cnt);
        e.ovf    = m_ovf;
        e.udf    = m_udf;
        exp_q.push_back(e);
        name_q.push_back(nm);

        if (rs) begin
            m_cnt = 0; m_head = 0; m_tail = 0; m_ovf = 0; m_udf = 0;
        end else begin
            push = w && (m_cnt < 8 || r);
            pop  = r && (m_cnt > 0);
            if (w && !r && m_cnt == 8) m_ovf = 1;
            else if (c)                m_ovf = 0;
            if (r && m_cnt == 0)       m_udf = 1;
            else if (c)                m_udf = 0;
            if (push) m_tail = (m_tail + 1) % 8;
            if (pop)  m_head = (m_head + 1) % 8;
            m_cnt = m_cnt + int'(push) - int'(pop);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            obs_t  e;
            obs_t  a;
            string nm;
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            a.wr_en  = bus.wr_en;
            a.w_addr = bus.w_addr;
            a.r_addr = bus.r_addr;
            a.full   = bus.full;
            a.empty  = bus.empty;
            a.afull  = bus.almost_full;
            a.aempty = bus.almost_empty;
            a.count  = bus.count;
            a.ovf    = bus.overflow;
            a.udf    = bus.underflow;
            tests++;
            if (a !== e) begin
                fails++;
                $display("[TB] FAIL %s: got %s, expected %s", nm, fmt(a), fmt(e));
            end else begin
                $display("[TB] ok   %s: %s", nm, fmt(a));
            end
        end
    end

    initial begin
        reset       = 1'b1;
        bus.wr      = 1'b0;
        bus.rd      = 1'b0;
        bus.clr_err = 1'b0;
        m_cnt = 0; m_head = 0; m_tail = 0; m_ovf = 0; m_udf = 0;
        repeat (2) @(posedge clk);

        // Reset state; a push during reset must not enable a write.
        step(1, 0, 0, 1, "reset_wr_ignored");
        step(0, 0, 0, 0, "reset_state");

        // Eight pushes: w_addr 0..7, then full.
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, $sformatf("push%0d", i));
        step(0, 0, 0, 0, "full_after_8");

        // Push while full is refused and raises overflow; clr_err clears it.
        step(1, 0, 0, 0, "push_when_full");
        step(0, 0, 0, 0, "overflow_set");
        step(0, 0, 1, 0, "clr_overflow");
        step(0, 0, 0, 0, "overflow_cleared");

        // Eight pops: r_addr 0..7, then empty; one more pop underflows.
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, $sformatf("pop%0d", i));
        step(0, 0, 0, 0, "empty_after_8");
        step(0, 1, 0, 0, "pop_when_empty");
        step(0, 0, 0, 0, "underflow_set");
        // Clear and a fresh underflow in the same cycle: flag stays set.
        step(0, 1, 1, 0, "clr_and_underflow");
        step(0, 0, 0, 0, "underflow_kept");
        step(0, 0, 1, 0, "clr_underflow");

        // Simultaneous push and pop while full.
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, $sformatf("refill%0d", i));
        step(1, 1, 0, 0, "rdwr_when_full");
        step(0, 0, 0, 0, "full_after_rdwr");
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, $sformatf("drain%0d", i));

        // Simultaneous push and pop while empty: only the push is taken.
        step(0, 0, 0, 0, "empty_before_rdwr");
        step(1, 1, 0, 0, "rdwr_when_empty");
        step(0, 0, 0, 0, "after_rdwr_empty");
        step(1, 1, 0, 0, "rdwr_mid");
        step(0, 0, 1, 0, "after_rdwr_mid");

        // Wrap the tail, fill, raise overflow, then reset mid-stream.
        step(0, 0, 0, 1, "reset2");
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, $sformatf("wpush%0d", i));
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, $sformatf("wpop%0d", i));
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, $sformatf("wrap_push%0d", i));
        step(0, 0, 0, 0, "full_after_wrap");
        step(1, 0, 0, 0, "overflow_after_wrap");
        step(0, 1, 0, 0, "underflow_not_raised");
        step(1, 0, 0, 1, "reset_mid_stream");
        step(0, 0, 0, 0, "after_mid_reset");

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain: %0d checks still pending, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_fifo_ctrl
